// File: rtl/microwave_pkg.sv
// Shared types, state encoding and BCD time arithmetic for the microwave cook timer.
package microwave_pkg;

   typedef logic [3:0] bcd_t;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ENTRY = 3'd1;
   localparam logic [2:0] ST_COOK  = 3'd2;
   localparam logic [2:0] ST_PAUSE = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam bcd_t        SEC_TENS_MAX  = 4'd5;
   localparam logic [15:0] QUICK_ADD_SEC = 16'h0030;

   // One-second countdown of {M10,M1,S10,S1}; callers never pass 00:00.
   function automatic logic [15:0] bcd_dec(input logic [15:0] t);
      bcd_t m10, m1, s10, s1;
      m10 = t[15:12];
      m1  = t[11:8];
      s10 = t[7:4];
      s1  = t[3:0];
      if (s1 != 4'd0) begin
         s1 = s1 - 4'd1;
      end else begin
         s1 = 4'd9;
         if (s10 != 4'd0) begin
            s10 = s10 - 4'd1;
         end else begin
            s10 = SEC_TENS_MAX;
            if (m1 != 4'd0) begin
               m1 = m1 - 4'd1;
            end else begin
               m1  = 4'd9;
               m10 = m10 - 4'd1;
            end
         end
      end
      return {m10, m1, s10, s1};
   endfunction

   // Adds a BCD seconds amount (< 60) with carry into minutes, saturating at 99:59.
   function automatic logic [15:0] bcd_add_sec(input logic [15:0] t, input logic [7:0] add);
      logic [4:0] s1s, s10s, m1s, m10s;
      logic       c;
      s1s = {1'b0, t[3:0]} + {1'b0, add[3:0]};
      c   = 1'b0;
      if (s1s > 5'd9) begin
         s1s = s1s - 5'd10;
         c   = 1'b1;
      end
      s10s = {1'b0, t[7:4]} + {1'b0, add[7:4]} + {4'b0, c};
      c    = 1'b0;
      if (s10s > {1'b0, SEC_TENS_MAX}) begin
         s10s = s10s - 5'd6;
         c    = 1'b1;
      end
      m1s = {1'b0, t[11:8]} + {4'b0, c};
      c   = 1'b0;
      if (m1s > 5'd9) begin
         m1s = m1s - 5'd10;
         c   = 1'b1;
      end
      m10s = {1'b0, t[15:12]} + {4'b0, c};
      if (m10s > 5'd9)
         return 16'h9959;
      return {m10s[3:0], m1s[3:0], s10s[3:0], s1s[3:0]};
   endfunction

endpackage

// File: rtl/microwave_timer_ctrl_if.sv
// Keypad/control inputs and display/heater outputs of the cook timer.
interface microwave_timer_ctrl_if;
   import microwave_pkg::*;

   logic        key_valid;
   bcd_t        key_digit;
   logic        start;
   logic        stop;
   logic        door_open;
   logic [15:0] time_bcd;
   logic [2:0]  state_o;
   logic        magnetron_on;
   logic        light_on;
   logic        beep;
   logic        done;

   modport master (
      output key_valid, key_digit, start, stop, door_open,
      input  time_bcd, state_o, magnetron_on, light_on, beep, done
   );

   modport slave (
      input  key_valid, key_digit, start, stop, door_open,
      output time_bcd, state_o, magnetron_on, light_on, beep, done
   );
endinterface

// File: rtl/microwave_timer_ctrl_tick_gen.sv
// Modulo-TICK_DIV counter; tick is high for the single cycle the count wraps to 0.
module tick_gen #(
   parameter int TICK_DIV = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] count;

   assign tick = en & (count == CW'(TICK_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en)
         count <= tick ? '0 : count + CW'(1);
   end
endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-cycle sequencer: keypad MM:SS entry, countdown, door interlock, end beep.
// Optional QUICK_ADD_EN: start adds 30 s (from IDLE it launches a 00:30 cook).
module microwave_timer_ctrl
   import microwave_pkg::*;
#(
   parameter int TICK_DIV   = 100,
   parameter int BEEP_TICKS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   microwave_timer_ctrl_if.slave bus
);
   logic [2:0]  state, state_nxt;
   logic [15:0] time_q, time_nxt, time_dec;
   logic        done_q, done_nxt;
   logic [7:0]  beep_cnt, beep_cnt_nxt;
   logic        tick, tick_en, tick_clr;
   logic        digit_ok, can_start;

   assign digit_ok  = bus.key_valid & (bus.key_digit <= 4'd9);
   assign can_start = ~bus.door_open & (time_q != 16'h0000) & (time_q[7:4] <= SEC_TENS_MAX);
   assign time_dec  = bcd_dec(time_q);

   // Freeze the phase in the cycle COOK is left so PAUSE resumes mid-second.
   assign tick_en = ((state == ST_COOK) & ~bus.door_open & ~bus.stop) | (state == ST_DONE);

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (tick_en),
      .clr  (tick_clr),
      .tick (tick)
   );

   always_comb begin
      state_nxt    = state;
      time_nxt     = time_q;
      done_nxt     = 1'b0;
      beep_cnt_nxt = beep_cnt;
      tick_clr     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!bus.stop) begin
`ifdef QUICK_ADD_EN
               if (bus.start && !bus.door_open && time_q == 16'h0000) begin
                  time_nxt  = QUICK_ADD_SEC;
                  state_nxt = ST_COOK;
                  tick_clr  = 1'b1;
               end else
`endif
               if (digit_ok) begin
                  time_nxt  = {time_q[11:0], bus.key_digit};
                  state_nxt = ST_ENTRY;
               end
            end
         end
         ST_ENTRY: begin
            if (bus.stop) begin
               time_nxt  = 16'h0000;
               state_nxt = ST_IDLE;
            end else if (bus.start) begin
               if (can_start) begin
                  state_nxt = ST_COOK;
                  tick_clr  = 1'b1;
               end
            end else if (digit_ok) begin
               time_nxt = {time_q[11:0], bus.key_digit};
            end
         end
         ST_COOK: begin
            if (bus.door_open || bus.stop) begin
               state_nxt = ST_PAUSE;
            end else if (bus.start) begin
`ifdef QUICK_ADD_EN
               time_nxt = bcd_add_sec(time_q, QUICK_ADD_SEC[7:0]);
`endif
            end else if (tick) begin
               time_nxt = time_dec;
               if (time_dec == 16'h0000) begin
                  state_nxt    = ST_DONE;
                  done_nxt     = 1'b1;
                  beep_cnt_nxt = 8'd0;
               end
            end
         end
         ST_PAUSE: begin
            if (bus.stop) begin
               time_nxt  = 16'h0000;
               state_nxt = ST_IDLE;
            end else if (bus.start && !bus.door_open) begin
               state_nxt = ST_COOK;
            end
         end
         ST_DONE: begin
            if (bus.stop) begin
               state_nxt = ST_IDLE;
            end else if (tick) begin
               if (beep_cnt == 8'(BEEP_TICKS - 1))
                  state_nxt = ST_IDLE;
               else
                  beep_cnt_nxt = beep_cnt + 8'd1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         time_q   <= 16'h0000;
         done_q   <= 1'b0;
         beep_cnt <= 8'd0;
      end else begin
         state    <= state_nxt;
         time_q   <= time_nxt;
         done_q   <= done_nxt;
         beep_cnt <= beep_cnt_nxt;
      end
   end

   // Heater gate stays combinational on the door switch: no clock edge between door and magnetron.
   assign bus.magnetron_on = (state == ST_COOK) & ~bus.door_open;
   assign bus.light_on     = bus.door_open | (state == ST_COOK) | (state == ST_PAUSE);
   assign bus.beep         = (state == ST_DONE);
   assign bus.done         = done_q;
   assign bus.time_bcd     = time_q;
   assign bus.state_o      = state;
endmodule
